savestates_reg_dump: RTL and testbench
======================================

# savestates_reg_dump

Savestate register-stream engine sitting directly downstream of the savestate register map. On save, it walks every shadow-register byte index and samples the map's `ss_do`/`ss_oe` read port. It packs the bytes little-endian into 64-bit words and writes them to savestate memory over a req/ack handshake. On load, it fetches those words back and replays each byte to the map as a register write.

## Interface

Parameters:
- `REG_COUNT`, default 64: number of shadow-register bytes, 1..256.
- `BASE_ADDR`, default 16'h0000: first savestate word address.

Ports:
- `clk`  in  1: system clock. Single clock domain; all logic is clocked on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `save_start`  in  1: one-cycle pulse that starts a dump.
- `load_start`  in  1: one-cycle pulse that starts a restore.
- `busy`  out  1: high while any transfer is in progress.
- `done`  out  1: one-cycle pulse when a transfer completes.
- `reg_idx`  out  8: byte index presented to the register map.
- `reg_rd`  out  1: read strobe toward the map.
- `ss_do`  in  8: map read data.
- `ss_oe`  in  1: map read data valid.
- `reg_wr`  out  1: replay write strobe.
- `reg_wdata`  out  8: replay write data.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: 1 = write, 0 = read.
- `mem_addr`  out  16: word address.
- `mem_wdata`  out  64: write data.
- `mem_rdata`  in  64: read data, valid while `mem_ack` is high.
- `mem_ack`  in  1: one-cycle request completion.

## Operation

- States: IDLE, S_RD, S_CAP, S_WR, L_REQ, L_WR, DONE.
- IDLE:
  - `save_start` -> S_RD with idx=0, word=0.
  - `load_start` -> L_REQ with idx=0, word=0.
  - Both pulses in the same cycle: save wins.
  - Start pulses are ignored when not in IDLE.
- S_RD: drive `reg_rd`=1 and `reg_idx`=idx, then go to S_CAP.
- S_CAP: capture the byte into lane idx%8 of the pack register, bits [8*(idx%8)+7 : 8*(idx%8)].
  - Captured value is `ss_do` if `ss_oe`=1, otherwise 8'h00.
  - Goes to S_WR if idx%8==7 or idx==REG_COUNT-1. Otherwise increment idx and go to S_RD.
- S_WR: hold `mem_req`=1, `mem_we`=1, `mem_addr`=BASE_ADDR+word, `mem_wdata`=pack until `mem_ack`.
  - On ack: clear pack to zero and increment word.
  - Then go to DONE if idx==REG_COUNT-1. Otherwise increment idx and go to S_RD.
- L_REQ: hold `mem_req`=1, `mem_we`=0, `mem_addr`=BASE_ADDR+word until `mem_ack`. Latch `mem_rdata` on ack, then go to L_WR.
- L_WR: one cycle per byte, driving `reg_wr`=1, `reg_idx`=idx, `reg_wdata`=lane idx%8.
  - After the last byte of the word, or idx==REG_COUNT-1: increment word and go to L_REQ, or to DONE when finished.
- DONE: `done`=1 for one cycle, then IDLE.
- Partial last word: unused lanes are written as 0 on save and never replayed on load.
- Words transferred = ceil(REG_COUNT/8). `mem_addr` arithmetic is modulo 2^16 and wraps silently.

## Timing

- Reset values: all outputs 0; state IDLE; idx, word and pack all 0.
- Reset mid-transfer: return to IDLE next cycle. Any outstanding `mem_req` drops and no `done` pulse is issued.
- `busy` is high from the cycle after an accepted start through the DONE cycle inclusive.
- Read latency: `ss_do`/`ss_oe` are sampled exactly one cycle after `reg_rd` (in S_CAP).
- Save cost: 2 cycles per byte plus, per word, the S_WR entry cycle and the ack wait.
- Load cost: per word, 1 request cycle plus the ack wait, plus 1 cycle per replayed byte.
- Handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable from req rise until the cycle `mem_ack` is seen.
  - `mem_req` is low in the cycle after ack.
  - An ack in the same cycle req rises is legal.
  - `mem_ack` while `mem_req`=0 is ignored.
- `reg_rd` and `reg_wr` are single-cycle and never asserted together.

## Test plan

- Save: REG_COUNT=16, map returns byte i = 8'hA0+i with `ss_oe`=1, ack after 3 cycles.
  - Expect two writes: addr 0 data 64'hA7A6A5A4A3A2A1A0, addr 1 data 64'hAFAEADACABAAA9A8.
  - Expect one `done` pulse.
- Partial word and `ss_oe` gaps: REG_COUNT=10, `ss_oe`=0 on idx 3.
  - Expect word 0 with lane 3 = 00.
  - Expect word 1 = 64'h00000000_0000A9A8.
- Load: REG_COUNT=10, BASE_ADDR=16'h0100, memory returns 64'h0706050403020100 then 64'h...0908.
  - Expect 10 `reg_wr` pulses with `reg_idx`/`reg_wdata` pairs 0/00 through 9/09, reads at 0100 and 0101.
- Arbitration: `save_start` and `load_start` in the same cycle -> save runs.
  - A `load_start` mid-save produces no effect.
- Reset with `mem_req` high and ack withheld -> next cycle `mem_req`=0, `busy`=0, no `done`.
  - A new `save_start` afterwards begins again at addr BASE_ADDR.
- Address wrap: BASE_ADDR=16'hFFFF, REG_COUNT=16 -> writes at FFFF then 0000.

Source files
------------

// File: rtl/savestates_reg_dump.sv
// Streams shadow-register bytes to savestate memory as packed little-endian 64-bit words (save) and replays them back as register writes (load).
// Save costs 2 cycles/byte plus per-word write handshake; load costs per-word read handshake plus 1 cycle/byte; memory stalls via req/ack.
module savestates_reg_dump #(
  parameter int          REG_COUNT = 64,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        save_start,
  input  logic        load_start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  reg_idx,
  output logic        reg_rd,
  input  logic [7:0]  ss_do,
  input  logic        ss_oe,
  output logic        reg_wr,
  output logic [7:0]  reg_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {IDLE, S_RD, S_CAP, S_WR, L_REQ, L_WR, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(REG_COUNT - 1);

  state_t      state, state_nxt;
  logic [7:0]  idx, idx_nxt;
  logic [15:0] word, word_nxt;
  logic [63:0] pack, pack_nxt;
  logic [63:0] rbuf, rbuf_nxt;

  logic [2:0]  lane;
  logic        last_byte;
  logic        word_end;

  assign lane      = idx[2:0];
  assign last_byte = (idx == LAST_IDX);
  // A word closes on its eighth lane or on the final register, whichever comes first.
  assign word_end  = (&idx[2:0]) || last_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 8'd0;
      word  <= 16'd0;
      pack  <= 64'd0;
      rbuf  <= 64'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      word  <= word_nxt;
      pack  <= pack_nxt;
      rbuf  <= rbuf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    word_nxt  = word;
    pack_nxt  = pack;
    rbuf_nxt  = rbuf;
    busy      = (state != IDLE);
    done      = 1'b0;
    reg_idx   = 8'd0;
    reg_rd    = 1'b0;
    reg_wr    = 1'b0;
    reg_wdata = 8'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'd0;
    mem_wdata = 64'd0;

    case (state)
      IDLE: begin
        if (save_start) begin
          state_nxt = S_RD;
          idx_nxt   = 8'd0;
          word_nxt  = 16'd0;
          pack_nxt  = 64'd0;
        end else if (load_start) begin
          state_nxt = L_REQ;
          idx_nxt   = 8'd0;
          word_nxt  = 16'd0;
        end
      end
      S_RD: begin
        reg_rd    = 1'b1;
        reg_idx   = idx;
        state_nxt = S_CAP;
      end
      S_CAP: begin
        pack_nxt[{lane, 3'b000} +: 8] = ss_oe ? ss_do : 8'h00;
        if (word_end) begin
          state_nxt = S_WR;
        end else begin
          idx_nxt   = idx + 8'd1;
          state_nxt = S_RD;
        end
      end
      S_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = BASE_ADDR + word;
        mem_wdata = pack;
        if (mem_ack) begin
          pack_nxt = 64'd0;
          word_nxt = word + 16'd1;
          if (last_byte) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 8'd1;
            state_nxt = S_RD;
          end
        end
      end
      L_REQ: begin
        mem_req  = 1'b1;
        mem_addr = BASE_ADDR + word;
        if (mem_ack) begin
          rbuf_nxt  = mem_rdata;
          state_nxt = L_WR;
        end
      end
      L_WR: begin
        reg_wr    = 1'b1;
        reg_idx   = idx;
        reg_wdata = rbuf[{lane, 3'b000} +: 8];
        if (word_end) begin
          word_nxt = word + 16'd1;
          if (last_byte) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 8'd1;
            state_nxt = L_REQ;
          end
        end else begin
          idx_nxt = idx + 8'd1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_savestates_reg_dump.sv
// Bench for savestates_reg_dump: three instances (16 regs @0000, 10 regs @0100, 16 regs @FFFF) with
// register-map and memory models; expected memory/register events go through one scoreboard queue.
module tb_savestates_reg_dump;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [63:0] data;
  } ev_t;

  localparam logic [1:0] EV_WR  = 2'd0;
  localparam logic [1:0] EV_RD  = 2'd1;
  localparam logic [1:0] EV_REG = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  save_start, load_start, busy, done, reg_rd, reg_wr, ss_oe;
  logic [2:0]  mem_req, mem_we, mem_ack;
  logic [7:0]  reg_idx [3];
  logic [7:0]  ss_do [3];
  logic [7:0]  reg_wdata [3];
  logic [15:0] mem_addr [3];
  logic [63:0] mem_wdata [3];
  logic [63:0] mem_rdata [3];

  logic [2:0]  hold, comb_ack, gap, ack_q;
  int          cnt [3];
  int          done_cnt [3] = '{0, 0, 0};
  int          total = 0;
  int          bad = 0;
  ev_t         exp_q [$];

  logic [2:0]  prev_req = 3'b000;
  logic [2:0]  prev_ack = 3'b000;
  logic [2:0]  prev_we;
  logic [15:0] prev_addr [3];
  logic [63:0] prev_wdata [3];

  function automatic logic [63:0] pattern(input logic [15:0] off);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(off * 8 + j);
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen
    localparam int          RC = (g == 1) ? 10 : 16;
    localparam logic [15:0] BA = (g == 0) ? 16'h0000 : (g == 1) ? 16'h0100 : 16'hFFFF;
    logic [15:0] off;
    assign off          = mem_addr[g] - BA;
    assign mem_ack[g]   = comb_ack[g] ? mem_req[g] : ack_q[g];
    assign mem_rdata[g] = pattern(off);

    savestates_reg_dump #(.REG_COUNT(RC), .BASE_ADDR(BA)) u_dut (
      .clk(clk), .reset(reset),
      .save_start(save_start[g]), .load_start(load_start[g]),
      .busy(busy[g]), .done(done[g]),
      .reg_idx(reg_idx[g]), .reg_rd(reg_rd[g]),
      .ss_do(ss_do[g]), .ss_oe(ss_oe[g]),
      .reg_wr(reg_wr[g]), .reg_wdata(reg_wdata[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .mem_ack(mem_ack[g])
    );
  end

  // Register map answers one cycle after reg_rd; index 3 reads back invalid when gap is set.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reg_rd[k]) begin
        ss_do[k] <= 8'hA0 + reg_idx[k];
        ss_oe[k] <= !(gap[k] && reg_idx[k] == 8'd3);
      end else begin
        ss_do[k] <= 8'h5A;
        ss_oe[k] <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        ack_q[k] <= 1'b0;
        cnt[k]   <= 0;
      end else if (ack_q[k]) begin
        ack_q[k] <= 1'b0;
        cnt[k]   <= 0;
      end else if (mem_req[k] && !hold[k] && !comb_ack[k]) begin
        if (cnt[k] == 2) ack_q[k] <= 1'b1;
        else             cnt[k] <= cnt[k] + 1;
      end
    end
  end

  task automatic chk(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  task automatic check_event(input int k, input ev_t got);
    ev_t e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL unexpected_event inst=%0d observed kind=%0d addr=%h data=%h expected none",
             k, got.kind, got.addr, got.data);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ev_kind", k, 64'(got.kind), 64'(e.kind));
      chk("ev_addr", k, 64'(got.addr), 64'(e.addr));
      chk("ev_data", k, got.data, e.data);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done[k] === 1'b1) done_cnt[k]++;
      if (mem_req[k] && mem_ack[k])
        check_event(k, '{kind: mem_we[k] ? EV_WR : EV_RD, addr: mem_addr[k],
                         data: mem_we[k] ? mem_wdata[k] : 64'h0});
      if (reg_wr[k] === 1'b1)
        check_event(k, '{kind: EV_REG, addr: {8'h00, reg_idx[k]}, data: {56'h0, reg_wdata[k]}});
      if (reg_rd[k] || reg_wr[k])
        chk("rd_wr_exclusive", k, 64'(reg_rd[k] & reg_wr[k]), 64'd0);
      if (prev_ack[k]) begin
        chk("req_low_after_ack", k, 64'(mem_req[k]), 64'd0);
      end else if (prev_req[k]) begin
        chk("req_held", k, 64'(mem_req[k]), 64'd1);
        chk("we_stable", k, 64'(mem_we[k]), 64'(prev_we[k]));
        chk("addr_stable", k, 64'(mem_addr[k]), 64'(prev_addr[k]));
        chk("wdata_stable", k, mem_wdata[k], prev_wdata[k]);
      end
      prev_req[k]   = (mem_req[k] === 1'b1) && !reset;
      prev_ack[k]   = (mem_req[k] === 1'b1) && (mem_ack[k] === 1'b1) && !reset;
      prev_we[k]    = mem_we[k];
      prev_addr[k]  = mem_addr[k];
      prev_wdata[k] = mem_wdata[k];
    end
  end

  task automatic push_ev(input logic [1:0] kind, input logic [15:0] addr, input logic [63:0] data);
    exp_q.push_back('{kind: kind, addr: addr, data: data});
  endtask

  task automatic start(input logic [2:0] s, input logic [2:0] l);
    @(posedge clk); #1;
    save_start = s;
    load_start = l;
    @(posedge clk); #1;
    save_start = 3'b000;
    load_start = 3'b000;
  endtask

  task automatic wait_done(input int k, input int target);
    int n = 0;
    while (done_cnt[k] < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_count", k, 64'(done_cnt[k]), 64'(target));
    repeat (10) @(negedge clk);
    chk("single_done", k, 64'(done_cnt[k]), 64'(target));
    chk("idle_after_done", k, 64'(busy[k]), 64'd0);
    chk("scoreboard_drained", k, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    save_start = 3'b000;
    load_start = 3'b000;
    hold = 3'b000;
    comb_ack = 3'b000;
    gap = 3'b000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, 64'(busy[k]), 64'd0);
      chk("rst_done", k, 64'(done[k]), 64'd0);
      chk("rst_mem_req", k, 64'(mem_req[k]), 64'd0);
      chk("rst_mem_we", k, 64'(mem_we[k]), 64'd0);
      chk("rst_mem_addr", k, 64'(mem_addr[k]), 64'd0);
      chk("rst_mem_wdata", k, mem_wdata[k], 64'd0);
      chk("rst_reg_rd", k, 64'(reg_rd[k]), 64'd0);
      chk("rst_reg_wr", k, 64'(reg_wr[k]), 64'd0);
      chk("rst_reg_idx", k, 64'(reg_idx[k]), 64'd0);
      chk("rst_reg_wdata", k, 64'(reg_wdata[k]), 64'd0);
    end

    // Save, 16 registers, delayed ack.
    push_ev(EV_WR, 16'h0000, 64'hA7A6A5A4A3A2A1A0);
    push_ev(EV_WR, 16'h0001, 64'hAFAEADACABAAA9A8);
    start(3'b001, 3'b000);
    chk("busy_after_start", 0, 64'(busy[0]), 64'd1);
    wait_done(0, 1);

    // Save, 10 registers with an invalid read at index 3 and a partial last word.
    gap[1] = 1'b1;
    push_ev(EV_WR, 16'h0100, 64'hA7A6A5A400A2A1A0);
    push_ev(EV_WR, 16'h0101, 64'h000000000000A9A8);
    start(3'b010, 3'b000);
    wait_done(1, 1);
    gap[1] = 1'b0;

    // Load, 10 registers from 0100.
    push_ev(EV_RD, 16'h0100, 64'h0);
    for (int i = 0; i < 8; i++) push_ev(EV_REG, 16'(i), 64'(i));
    push_ev(EV_RD, 16'h0101, 64'h0);
    for (int i = 8; i < 10; i++) push_ev(EV_REG, 16'(i), 64'(i));
    start(3'b000, 3'b010);
    chk("busy_after_load", 1, 64'(busy[1]), 64'd1);
    wait_done(1, 2);

    // Simultaneous starts pick save; a load pulse mid-save is dropped.
    push_ev(EV_WR, 16'h0000, 64'hA7A6A5A4A3A2A1A0);
    push_ev(EV_WR, 16'h0001, 64'hAFAEADACABAAA9A8);
    start(3'b001, 3'b001);
    repeat (5) @(posedge clk);
    #1 load_start[0] = 1'b1;
    @(posedge clk);
    #1 load_start[0] = 1'b0;
    wait_done(0, 2);

    // Reset while a write request is stalled.
    hold[0] = 1'b1;
    start(3'b001, 3'b000);
    n = 0;
    while (mem_req[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stalled_req_seen", 0, 64'(mem_req[0]), 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("req_after_reset", 0, 64'(mem_req[0]), 64'd0);
    chk("busy_after_reset", 0, 64'(busy[0]), 64'd0);
    hold[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_done_on_reset", 0, 64'(done_cnt[0]), 64'd2);
    push_ev(EV_WR, 16'h0000, 64'hA7A6A5A4A3A2A1A0);
    push_ev(EV_WR, 16'h0001, 64'hAFAEADACABAAA9A8);
    start(3'b001, 3'b000);
    wait_done(0, 3);

    // Address wrap from FFFF, ack in the same cycle as req.
    comb_ack[2] = 1'b1;
    push_ev(EV_WR, 16'hFFFF, 64'hA7A6A5A4A3A2A1A0);
    push_ev(EV_WR, 16'h0000, 64'hAFAEADACABAAA9A8);
    start(3'b100, 3'b000);
    wait_done(2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
